// File: rtl/interrupt_dispatcher.sv
// interrupt_dispatcher: collects rising-edge peripheral requests, picks the lowest-index
// eligible source and drives one vector PC plus a one-hot core trigger to the interrupt
// controller. One dispatch is in flight at a time; the trigger is held until the target
// core acknowledges.
// Optional feature macro: INT_DISPATCH_TIMEOUT_EN (ack timeout with sticky timeout_flag).
module interrupt_dispatcher #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDRESS_BITS   = 20,
    parameter int unsigned NUM_CORES      = 2,
    parameter int unsigned NUM_SOURCES    = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    localparam int unsigned SRC_BITS      = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1,
    localparam int unsigned CORE_BITS     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_SOURCES-1:0]  irq_in,
    input  logic                    cfg_write,
    input  logic [SRC_BITS-1:0]     cfg_source,
    input  logic [ADDRESS_BITS-1:0] cfg_vector,
    input  logic [CORE_BITS-1:0]    cfg_core,
    input  logic                    cfg_enable,
    input  logic [NUM_CORES-1:0]    irq_ack,
    output logic [ADDRESS_BITS-1:0] interrupt_PC_out,
    output logic [DATA_WIDTH-1:0]   interrupt_trigger_out,
    output logic [NUM_SOURCES-1:0]  pending_out,
    output logic                    busy,
    output logic                    timeout_flag
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FIRE = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [NUM_SOURCES-1:0]  irq_q;
    logic [NUM_SOURCES-1:0]  rise;
    logic [NUM_SOURCES-1:0]  set_mask;
    logic [NUM_SOURCES-1:0]  clr_mask;
    logic [NUM_SOURCES-1:0]  eligible;
    logic [NUM_SOURCES-1:0]  pending;
    logic [NUM_SOURCES-1:0]  enable;
    logic [ADDRESS_BITS-1:0] vector   [NUM_SOURCES];
    logic [CORE_BITS-1:0]    core_sel [NUM_SOURCES];

    logic [SRC_BITS-1:0]     act_src;
    logic [CORE_BITS-1:0]    act_core;

    logic                    win_valid;
    logic [SRC_BITS-1:0]     win_src;
    logic                    cfg_ok;
    logic                    launch;
    logic                    ack_hit;
    logic                    timeout_hit;

`ifdef INT_DISPATCH_TIMEOUT_EN
    localparam int unsigned TO_BITS = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_BITS-1:0] fire_cnt;
`endif

    assign rise        = irq_in & ~irq_q;
    assign set_mask    = rise & enable;
    assign eligible    = pending & enable;
    assign pending_out = pending;
    assign cfg_ok      = cfg_write
                         && (32'(cfg_core) < NUM_CORES)
                         && (32'(cfg_source) < NUM_SOURCES);
    assign clr_mask    = ack_hit ? (NUM_SOURCES'(1) << act_src) : '0;

    // Fixed-priority pick: lowest eligible index wins
    always_comb begin
        win_valid = 1'b0;
        win_src   = '0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_valid = 1'b1;
                win_src   = SRC_BITS'(i);
            end
        end
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state and dispatch control
    always_comb begin
        state_next  = state;
        launch      = 1'b0;
        ack_hit     = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            ST_IDLE: begin
                if (win_valid) begin
                    launch     = 1'b1;
                    state_next = ST_FIRE;
                end
            end
            ST_FIRE: begin
                if (irq_ack[act_core]) begin
                    ack_hit    = 1'b1;
                    state_next = ST_GAP;
                end
`ifdef INT_DISPATCH_TIMEOUT_EN
                else if (fire_cnt == TO_BITS'(TIMEOUT_CYCLES - 1)) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_GAP;
                end
`endif
            end
            ST_GAP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Request edge detection and pending set/clear (a new set beats an ack clear)
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            irq_q   <= '0;
            pending <= '0;
        end else begin
            irq_q   <= irq_in;
            pending <= (pending & ~clr_mask) | set_mask;
        end
    end

    // Per-source configuration table; writes naming a nonexistent core are dropped
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            enable <= '0;
            for (int i = 0; i < NUM_SOURCES; i++) begin
                vector[i]   <= '0;
                core_sel[i] <= '0;
            end
        end else if (cfg_ok) begin
            vector[cfg_source]   <= cfg_vector;
            core_sel[cfg_source] <= cfg_core;
            enable[cfg_source]   <= cfg_enable;
        end
    end

    // Dispatch datapath: latch winner on launch, drop trigger on ack or timeout
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            act_src               <= '0;
            act_core              <= '0;
            interrupt_PC_out      <= '0;
            interrupt_trigger_out <= '0;
            busy                  <= 1'b0;
        end else begin
            busy <= (state_next != ST_IDLE);
            if (launch) begin
                act_src               <= win_src;
                act_core              <= core_sel[win_src];
                interrupt_PC_out      <= vector[win_src];
                interrupt_trigger_out <= DATA_WIDTH'(1) << core_sel[win_src];
            end else if (ack_hit || timeout_hit) begin
                interrupt_trigger_out <= '0;
            end
        end
    end

`ifdef INT_DISPATCH_TIMEOUT_EN
    // Ack timeout counter (cycles spent in FIRE) and sticky flag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fire_cnt     <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (launch) begin
                fire_cnt <= '0;
            end else if (state == ST_FIRE) begin
                fire_cnt <= fire_cnt + TO_BITS'(1);
            end
            if (timeout_hit) begin
                timeout_flag <= 1'b1;
            end
        end
    end
`else
    assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_interrupt_dispatcher.sv
// Self-checking bench for interrupt_dispatcher: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model of the dispatch rules.
module tb_interrupt_dispatcher;

    localparam int unsigned DW = 32;
    localparam int unsigned AB = 20;
    localparam int unsigned NC = 3;
    localparam int unsigned NS = 8;
    localparam int unsigned TO = 4;
    localparam int unsigned SB = 3;
    localparam int unsigned CB = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic [NS-1:0] irq_in;
    logic          cfg_write;
    logic [SB-1:0] cfg_source;
    logic [AB-1:0] cfg_vector;
    logic [CB-1:0] cfg_core;
    logic          cfg_enable;
    logic [NC-1:0] irq_ack;
    logic [AB-1:0] interrupt_PC_out;
    logic [DW-1:0] interrupt_trigger_out;
    logic [NS-1:0] pending_out;
    logic          busy;
    logic          timeout_flag;

    interrupt_dispatcher #(
        .DATA_WIDTH    (DW),
        .ADDRESS_BITS  (AB),
        .NUM_CORES     (NC),
        .NUM_SOURCES   (NS),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .irq_in               (irq_in),
        .cfg_write            (cfg_write),
        .cfg_source           (cfg_source),
        .cfg_vector           (cfg_vector),
        .cfg_core             (cfg_core),
        .cfg_enable           (cfg_enable),
        .irq_ack              (irq_ack),
        .interrupt_PC_out     (interrupt_PC_out),
        .interrupt_trigger_out(interrupt_trigger_out),
        .pending_out          (pending_out),
        .busy                 (busy),
        .timeout_flag         (timeout_flag)
    );

    always #5 clock = ~clock;

    // Behavioural model state
    logic [NS-1:0] m_pend;
    logic [NS-1:0] m_irq_q;
    logic [NS-1:0] m_en;
    logic [AB-1:0] m_vec [NS];
    int            m_core [NS];
    logic [AB-1:0] m_pc;
    logic [DW-1:0] m_trig;
    logic          m_to;
    int            m_phase;      // 0 waiting, 1 trigger held, 2 one-cycle gap
    int            m_src;
    int            m_cur_core;
    int            m_fire_cycles;

    int vectors;
    int miscompares;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = '0; m_irq_q = '0; m_en = '0; m_pc = '0; m_trig = '0; m_to = 1'b0;
        m_phase = 0; m_src = 0; m_cur_core = 0; m_fire_cycles = 0;
        for (int i = 0; i < NS; i++) begin
            m_vec[i] = '0;
            m_core[i] = 0;
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied
    task automatic model_edge();
        logic [NS-1:0] rise;
        logic [NS-1:0] setm;
        logic [NS-1:0] clr;
        logic [NS-1:0] elig;
        int win;
        rise = irq_in & ~m_irq_q;
        setm = rise & m_en;
        clr  = '0;
        if (m_phase == 0) begin
            elig = m_pend & m_en;
            win  = -1;
            for (int i = NS - 1; i >= 0; i--) if (elig[i]) win = i;
            if (win >= 0) begin
                m_src         = win;
                m_cur_core    = m_core[win];
                m_pc          = m_vec[win];
                m_trig        = '0;
                m_trig[m_core[win]] = 1'b1;
                m_phase       = 1;
                m_fire_cycles = 0;
            end
        end else if (m_phase == 1) begin
            if (irq_ack[m_cur_core]) begin
                clr[m_src] = 1'b1;
                m_trig     = '0;
                m_phase    = 2;
            end
`ifdef INT_DISPATCH_TIMEOUT_EN
            else begin
                m_fire_cycles++;
                if (m_fire_cycles == TO) begin
                    m_trig  = '0;
                    m_to    = 1'b1;
                    m_phase = 2;
                end
            end
`endif
        end else begin
            m_phase = 0;
        end
        m_pend = (m_pend & ~clr) | setm;
        if (cfg_write && (int'(cfg_core) < NC)) begin
            m_vec[cfg_source]  = cfg_vector;
            m_core[cfg_source] = int'(cfg_core);
            m_en[cfg_source]   = cfg_enable;
        end
        m_irq_q = irq_in;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".trigger"}, 64'(interrupt_trigger_out), 64'(m_trig));
        chk({tag, ".pc"},      64'(interrupt_PC_out),      64'(m_pc));
        chk({tag, ".pending"}, 64'(pending_out),           64'(m_pend));
        chk({tag, ".busy"},    64'(busy),                  64'(m_phase != 0));
        chk({tag, ".timeout"}, 64'(timeout_flag),          64'(m_to));
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clock);
        #1;
        check_outputs(tag);
    endtask

    task automatic cfg(input int src, input logic [AB-1:0] vec, input int core, input logic en);
        cfg_write  = 1'b1;
        cfg_source = SB'(src);
        cfg_vector = vec;
        cfg_core   = CB'(core);
        cfg_enable = en;
        tick("cfg");
        cfg_write  = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        irq_in      = '0;
        cfg_write   = 1'b0;
        cfg_source  = '0;
        cfg_vector  = '0;
        cfg_core    = '0;
        cfg_enable  = 1'b0;
        irq_ack     = '0;
        model_reset();
        #1;
        check_outputs("reset");
        @(posedge clock);
        #1;
        reset = 1'b1;
        tick("idle");

        // Single dispatch: src3 -> core1 at 0x00400
        cfg(3, 20'h00400, 1, 1'b1);
        irq_in[3] = 1'b1;
        tick("single_edge");
        chk("single_pend3", 64'(pending_out[3]), 64'd1);
        chk("single_trig_early", 64'(interrupt_trigger_out), 64'd0);
        tick("single_fire");
        chk("single_trig", 64'(interrupt_trigger_out), 64'h2);
        chk("single_pc", 64'(interrupt_PC_out), 64'h00400);
        irq_ack = 3'b001;
        tick("wrong_ack");
        chk("wrong_ack_trig", 64'(interrupt_trigger_out), 64'h2);
        irq_ack = 3'b010;
        tick("ack");
        chk("ack_trig", 64'(interrupt_trigger_out), 64'd0);
        chk("ack_pend3", 64'(pending_out[3]), 64'd0);
        chk("gap_busy", 64'(busy), 64'd1);
        irq_ack = '0;
        tick("after_gap");
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_pc_held", 64'(interrupt_PC_out), 64'h00400);

        // Disabled source: edge ignored
        irq_in[6] = 1'b1;
        tick("disabled");
        chk("disabled_pend6", 64'(pending_out[6]), 64'd0);

        // Priority: src2 and src5 together
        cfg(2, 20'h00200, 0, 1'b1);
        cfg(5, 20'h00500, 2, 1'b1);
        irq_in[2] = 1'b1;
        irq_in[5] = 1'b1;
        tick("prio_edge");
        chk("prio_pend", 64'(pending_out & 8'h24), 64'h24);
        tick("prio_fire2");
        chk("prio_pc2", 64'(interrupt_PC_out), 64'h00200);
        chk("prio_trig2", 64'(interrupt_trigger_out), 64'h1);
        tick("prio_hold");
        irq_ack = 3'b001;
        tick("prio_ack2");
        irq_ack = '0;
        tick("prio_gap");
        tick("prio_fire5");
        chk("prio_pc5", 64'(interrupt_PC_out), 64'h00500);
        chk("prio_trig5", 64'(interrupt_trigger_out), 64'h4);
        irq_ack = 3'b100;
        tick("prio_ack5");
        irq_ack = '0;
        tick("prio_gap5");
        tick("prio_idle");

        // Set wins over ack clear on the active source
        irq_in[3] = 1'b0;
        tick("sw_low");
        irq_in[3] = 1'b1;
        tick("sw_edge");
        tick("sw_fire");
        irq_in[3] = 1'b0;
        tick("sw_low2");
        irq_in[3] = 1'b1;
        irq_ack   = 3'b010;
        tick("sw_ack");
        chk("sw_pend3", 64'(pending_out[3]), 64'd1);
        chk("sw_trig0", 64'(interrupt_trigger_out), 64'd0);
        irq_ack = '0;
        tick("sw_gap");
        tick("sw_refire");
        chk("sw_trig2", 64'(interrupt_trigger_out), 64'h2);
        irq_ack = 3'b010;
        tick("sw_ack2");
        irq_ack = '0;
        tick("sw_gap2");
        tick("sw_idle");

`ifdef INT_DISPATCH_TIMEOUT_EN
        // Timeout: no ack for TO FIRE cycles
        irq_in[3] = 1'b0;
        tick("to_low");
        irq_in[3] = 1'b1;
        tick("to_edge");
        tick("to_fire");
        for (int i = 0; i < TO; i++) tick("to_wait");
        chk("to_trig", 64'(interrupt_trigger_out), 64'd0);
        chk("to_flag", 64'(timeout_flag), 64'd1);
        chk("to_pend3", 64'(pending_out[3]), 64'd1);
        tick("to_gap");
        tick("to_refire");
        chk("to_retrig", 64'(interrupt_trigger_out), 64'h2);
        irq_ack = 3'b010;
        tick("to_ack");
        irq_ack = '0;
        tick("to_gap2");
`else
        chk("no_timeout_flag", 64'(timeout_flag), 64'd0);
`endif

        // Reset asserted mid-dispatch
        irq_in[3] = 1'b0;
        tick("rst_low");
        irq_in[3] = 1'b1;
        tick("rst_edge");
        tick("rst_fire");
        chk("rst_pre_trig", 64'(interrupt_trigger_out), 64'h2);
        reset = 1'b0;
        #1;
        chk("rst_trig", 64'(interrupt_trigger_out), 64'd0);
        chk("rst_pc", 64'(interrupt_PC_out), 64'd0);
        chk("rst_pend", 64'(pending_out), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        model_reset();
        @(posedge clock);
        #1;
        reset  = 1'b1;
        irq_in = '0;
        tick("rst_rel");
        irq_in[3] = 1'b1;
        tick("rst_en_cleared");
        chk("rst_en_pend3", 64'(pending_out[3]), 64'd0);

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            irq_in     = NS'($urandom);
            irq_ack    = ($urandom_range(0, 3) == 0) ? NC'($urandom) : '0;
            cfg_write  = ($urandom_range(0, 7) == 0);
            cfg_source = SB'($urandom);
            cfg_vector = AB'($urandom);
            cfg_core   = CB'($urandom_range(0, 3));
            cfg_enable = ($urandom_range(0, 3) != 0);
            tick("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
